evt_window_buffer: RTL and testbench
====================================

Name: evt_window_buffer

Overview:
- Parametrised single-clock event buffer for the DCFEB sample path. It captures a programmable window of multi-channel ADC sample words on each matched L1A and stores them in an internal data FIFO.
- For each accepted trigger it pushes a 44-bit header (L1A/match counts, overlap info) into a header FIFO.
- Generalises the 16-channel, 12-bit fixed design to NCH channels of DW bits, with configurable depths.
- Adds window extension on overlap, space reservation with trigger rejection, and drop accounting.

Parameters:
NCH, 16, number of channels per sample word
DW, 12, bits per channel
DAW, 9, data FIFO address width (depth 2^DAW sample words)
HAW, 4, header FIFO address width (depth 2^HAW headers)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_N  in  1  asynchronous active-low reset
RESYNC  in  1  synchronous resync request, one-cycle pulse
L1A  in  1  level-1 accept pulse
L1A_MATCH  in  1  matched L1A pulse (trigger)
SMP_EN  in  1  one-cycle strobe: DIN holds a valid sample this cycle
SAMP_MAX  in  7  samples per event minus 1; static while RDY=0 and no window is open
DIN  in  NCH*DW  sample word, channel 0 in LSBs
RD_EN  in  1  data FIFO read request
DOUT  out  NCH*DW  data FIFO read word
DOUT_VLD  out  1  DOUT updated this cycle
HDR_RD_EN  in  1  header FIFO read request
HDR_OUT  out  44  {OVLP, SHARED[6:0], L1AMCNT[11:0], L1ACNT[23:0]}
HDR_VLD  out  1  HDR_OUT updated this cycle
RDY  out  1  header FIFO not empty
DATA_CNT  out  DAW+1  words in data FIFO
DROP_CNT  out  8  rejected triggers, saturating at 255
OVF  out  1  sticky: at least one trigger rejected

Behaviour:
- Async reset (RST_N=0): all pointers, counters and flags go to 0.
  - Outputs: DOUT=0, DOUT_VLD=0, HDR_OUT=0, HDR_VLD=0, RDY=0, DATA_CNT=0, DROP_CNT=0, OVF=0. Window closed, REM=0.
- Resync:
  - A RESYNC pulse asserts an internal clear for 4 cycles (the RESYNC cycle plus the next 3).
  - The clear acts like reset, except DOUT and HDR_OUT hold their values.
  - L1A, L1A_MATCH and SMP_EN are ignored while the clear is active.
- Counters:
  - L1ACNT (24b) increments on L1A.
  - L1AMCNT (12b) increments on L1A_MATCH.
  - Both wrap modulo width.
  - A header records the post-increment values of the trigger cycle.
- Window state:
  - REM (8b) holds the samples still to be written; the window is open when REM>0.
  - Each cycle with SMP_EN and REM>0 writes DIN to the data FIFO and decrements REM.
- Trigger (L1A_MATCH=1), with N=SAMP_MAX+1 and NEED = N-REM (REM sampled before this cycle's decrement):
  - Accepted if the data FIFO has free space >= NEED and the header FIFO is not full. Free space = 2^DAW - DATA_CNT - REM, i.e. outstanding writes are reserved.
  - Accept: REM is reloaded to N and the window is extended, never duplicated.
  - Header written the same cycle with OVLP=(REM>0) and SHARED=REM (pre-trigger value, saturated to 127). SHARED tells downstream that this event's first SHARED samples are the previous event's last samples.
  - Reject: no header, REM unchanged, DROP_CNT+1 (saturating), OVF=1.
  - If SMP_EN coincides with an accepted trigger, the current DIN is sample 0 of the new window. REM then becomes N-1 at the next edge.
- Reservation guarantees the data FIFO never overflows; a write attempt at full is a design error (assertion in bench).
- Reads:
  - RD_EN with data non-empty pops one word; DOUT is registered and DOUT_VLD=1 the next cycle.
  - RD_EN on empty is ignored: DOUT_VLD=0 and DOUT holds.
  - HDR_RD_EN behaves identically for the header FIFO and HDR_OUT/HDR_VLD.
- Simultaneous read and write: allowed on either FIFO. DATA_CNT changes by net +/-0/1.
- Pointers are DAW+1 (HAW+1) bits with an MSB wrap flag. Full means the address bits are equal and the MSBs differ.
- RDY is registered, 1 cycle after the header write.
- SAMP_MAX=0 gives 1-sample events. N must be <= 2^DAW, otherwise every trigger is rejected.

Test Plan:
- Reset release, SAMP_MAX=7, SMP_EN every 2nd cycle, one L1A+L1A_MATCH -> 8 words written in order. HDR_OUT={0,0,12'd1,24'd1}, RDY=1 one cycle after the trigger, DATA_CNT=8.
- Second match when REM=3 -> header OVLP=1, SHARED=3. Total written = 8+5 = 13 words.
- Fill: DAW=4, SAMP_MAX=7, three spaced triggers with no reads -> third trigger rejected, DROP_CNT=1, OVF=1, DATA_CNT=16. Header FIFO holds 2 entries.
- Drain via RD_EN back-to-back -> DOUT_VLD high for 16 cycles with data in write order. A 17th RD_EN gives DOUT_VLD=0 with DOUT unchanged.
- RESYNC mid-window -> within 4 cycles DATA_CNT=0, RDY=0, counters 0. Next trigger header shows L1AMCNT=1.
- RST_N low mid-operation, asynchronously between edges -> all outputs 0 immediately. Pointer wrap verified over 3 full fills with DAW=4.

Source files
------------

// File: rtl/evt_window_buffer.sv
// evt_window_buffer
// Captures a programmable window of NCH x DW sample words for each matched
// L1A into a data FIFO and queues one 44-bit header per accepted trigger.
// Overlapping triggers extend the open window instead of duplicating samples.
// A trigger is rejected when the data FIFO cannot reserve room for the whole
// window, so the data FIFO cannot overflow.
module evt_window_buffer #(
  parameter int NCH = 16,
  parameter int DW  = 12,
  parameter int DAW = 9,
  parameter int HAW = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RESYNC,
  input  logic              L1A,
  input  logic              L1A_MATCH,
  input  logic              SMP_EN,
  input  logic [6:0]        SAMP_MAX,
  input  logic [NCH*DW-1:0] DIN,
  input  logic              RD_EN,
  output logic [NCH*DW-1:0] DOUT,
  output logic              DOUT_VLD,
  input  logic              HDR_RD_EN,
  output logic [43:0]       HDR_OUT,
  output logic              HDR_VLD,
  output logic              RDY,
  output logic [DAW:0]      DATA_CNT,
  output logic [7:0]        DROP_CNT,
  output logic              OVF
);

  localparam int WW     = NCH * DW;
  localparam int HW     = 44;
  localparam int DDEPTH = 1 << DAW;
  localparam int HDEPTH = 1 << HAW;
  localparam logic [DAW:0] D_ONE = {{DAW{1'b0}}, 1'b1};
  localparam logic [HAW:0] H_ONE = {{HAW{1'b0}}, 1'b1};

  // ---------------------------------------------------------------- state
  logic [1:0]    r_clr_cnt;
  logic [23:0]   r_l1a_cnt;
  logic [11:0]   r_l1am_cnt;
  logic [7:0]    r_rem;
  logic [DAW:0]  r_dwp;
  logic [DAW:0]  r_drp;
  logic [DAW:0]  r_dcnt;
  logic [HAW:0]  r_hwp;
  logic [HAW:0]  r_hrp;
  logic [HAW:0]  r_hcnt;
  logic [7:0]    r_drop;
  logic          r_ovf;
  logic          r_rdy;
  logic          r_dvld;
  logic          r_hvld;
  logic [WW-1:0] r_dout;
  logic [HW-1:0] r_hdr;
  logic [WW-1:0] r_dmem [DDEPTH];
  logic [HW-1:0] r_hmem [HDEPTH];

  // ---------------------------------------------------------------- wires
  logic          w_clr;
  logic          w_l1a;
  logic          w_trg;
  logic          w_smp;
  logic [7:0]    w_n;
  logic [31:0]   w_dspace;
  logic          w_dempty;
  logic          w_dfull;
  logic          w_hempty;
  logic          w_hfull;
  logic          w_accept;
  logic          w_reject;
  logic          w_dwr;
  logic          w_drd;
  logic          w_hwr;
  logic          w_hrd;
  logic [7:0]    w_rem_nxt;
  logic [6:0]    w_shared;
  logic          w_ovlp;
  logic [23:0]   w_l1a_nxt;
  logic [11:0]   w_l1am_nxt;
  logic [HW-1:0] w_hdr_in;
  logic [DAW:0]  w_dcnt_nxt;
  logic [HAW:0]  w_hcnt_nxt;
  logic [7:0]    w_drop_nxt;

  // Clear window (RESYNC cycle plus three more) gates all event inputs.
  always_comb begin
    w_clr = RESYNC | (r_clr_cnt != 2'd0);
    w_l1a = L1A & ~w_clr;
    w_trg = L1A_MATCH & ~w_clr;
    w_smp = SMP_EN & ~w_clr;
  end

  // FIFO status from the wrap-flagged pointers.
  always_comb begin
    w_dempty = (r_dwp == r_drp);
    w_dfull  = (r_dwp[DAW-1:0] == r_drp[DAW-1:0]) && (r_dwp[DAW] != r_drp[DAW]);
    w_hempty = (r_hwp == r_hrp);
    w_hfull  = (r_hwp[HAW-1:0] == r_hrp[HAW-1:0]) && (r_hwp[HAW] != r_hrp[HAW]);
  end

  // Trigger admission: free space minus reserved REM must cover N-REM,
  // which reduces to depth-DATA_CNT >= N.
  always_comb begin
    w_n      = {1'b0, SAMP_MAX} + 8'd1;
    w_dspace = 32'(DDEPTH) - 32'(r_dcnt);
    w_accept = w_trg && (w_dspace >= 32'(w_n)) && !w_hfull;
    w_reject = w_trg && !w_accept;
    w_dwr    = w_smp && (w_accept || (r_rem != 8'd0)) && !w_dfull;
    w_drd    = RD_EN && !w_dempty && !w_clr;
    w_hwr    = w_accept;
    w_hrd    = HDR_RD_EN && !w_hempty && !w_clr;
  end

  // Remaining-sample count: reload on accept (current sample counts as #0).
  always_comb begin
    w_rem_nxt = r_rem;
    if (w_accept) begin
      if (w_smp) begin
        w_rem_nxt = w_n - 8'd1;
      end else begin
        w_rem_nxt = w_n;
      end
    end else if (w_smp && (r_rem != 8'd0)) begin
      w_rem_nxt = r_rem - 8'd1;
    end else begin
      w_rem_nxt = r_rem;
    end
  end

  // Header content uses post-increment counters and pre-trigger REM.
  always_comb begin
    w_l1a_nxt  = r_l1a_cnt + {23'd0, w_l1a};
    w_l1am_nxt = r_l1am_cnt + {11'd0, w_trg};
    w_ovlp     = (r_rem != 8'd0);
    if (r_rem > 8'd127) begin
      w_shared = 7'd127;
    end else begin
      w_shared = r_rem[6:0];
    end
    w_hdr_in = {w_ovlp, w_shared, w_l1am_nxt, w_l1a_nxt};
  end

  // Occupancy counters follow net push/pop; drop count saturates.
  always_comb begin
    w_dcnt_nxt = r_dcnt;
    case ({w_dwr, w_drd})
      2'b10:   w_dcnt_nxt = r_dcnt + D_ONE;
      2'b01:   w_dcnt_nxt = r_dcnt - D_ONE;
      default: w_dcnt_nxt = r_dcnt;
    endcase
    w_hcnt_nxt = r_hcnt;
    case ({w_hwr, w_hrd})
      2'b10:   w_hcnt_nxt = r_hcnt + H_ONE;
      2'b01:   w_hcnt_nxt = r_hcnt - H_ONE;
      default: w_hcnt_nxt = r_hcnt;
    endcase
    if (w_reject && (r_drop != 8'd255)) begin
      w_drop_nxt = r_drop + 8'd1;
    end else begin
      w_drop_nxt = r_drop;
    end
  end

  // Resync clear sequencer: load 3 so clear spans four cycles in total.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_clr_cnt <= 2'd0;
    end else if (RESYNC) begin
      r_clr_cnt <= 2'd3;
    end else if (r_clr_cnt != 2'd0) begin
      r_clr_cnt <= r_clr_cnt - 2'd1;
    end
  end

  // Control state: counters, window, pointers, flags (cleared by resync too).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_l1a_cnt  <= 24'd0;
      r_l1am_cnt <= 12'd0;
      r_rem      <= 8'd0;
      r_dwp      <= {(DAW+1){1'b0}};
      r_drp      <= {(DAW+1){1'b0}};
      r_dcnt     <= {(DAW+1){1'b0}};
      r_hwp      <= {(HAW+1){1'b0}};
      r_hrp      <= {(HAW+1){1'b0}};
      r_hcnt     <= {(HAW+1){1'b0}};
      r_drop     <= 8'd0;
      r_ovf      <= 1'b0;
      r_rdy      <= 1'b0;
      r_dvld     <= 1'b0;
      r_hvld     <= 1'b0;
    end else if (w_clr) begin
      r_l1a_cnt  <= 24'd0;
      r_l1am_cnt <= 12'd0;
      r_rem      <= 8'd0;
      r_dwp      <= {(DAW+1){1'b0}};
      r_drp      <= {(DAW+1){1'b0}};
      r_dcnt     <= {(DAW+1){1'b0}};
      r_hwp      <= {(HAW+1){1'b0}};
      r_hrp      <= {(HAW+1){1'b0}};
      r_hcnt     <= {(HAW+1){1'b0}};
      r_drop     <= 8'd0;
      r_ovf      <= 1'b0;
      r_rdy      <= 1'b0;
      r_dvld     <= 1'b0;
      r_hvld     <= 1'b0;
    end else begin
      r_l1a_cnt  <= w_l1a_nxt;
      r_l1am_cnt <= w_l1am_nxt;
      r_rem      <= w_rem_nxt;
      r_dwp      <= w_dwr ? (r_dwp + D_ONE) : r_dwp;
      r_drp      <= w_drd ? (r_drp + D_ONE) : r_drp;
      r_dcnt     <= w_dcnt_nxt;
      r_hwp      <= w_hwr ? (r_hwp + H_ONE) : r_hwp;
      r_hrp      <= w_hrd ? (r_hrp + H_ONE) : r_hrp;
      r_hcnt     <= w_hcnt_nxt;
      r_drop     <= w_drop_nxt;
      r_ovf      <= r_ovf | w_reject;
      r_rdy      <= (w_hcnt_nxt != {(HAW+1){1'b0}});
      r_dvld     <= w_drd;
      r_hvld     <= w_hrd;
    end
  end

  // Read data registers: only reset clears them, resync leaves them holding.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dout <= {WW{1'b0}};
      r_hdr  <= {HW{1'b0}};
    end else begin
      if (w_drd) begin
        r_dout <= r_dmem[r_drp[DAW-1:0]];
      end
      if (w_hrd) begin
        r_hdr <= r_hmem[r_hrp[HAW-1:0]];
      end
    end
  end

  // Storage arrays carry no reset; pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (w_dwr) begin
      r_dmem[r_dwp[DAW-1:0]] <= DIN;
    end
    if (w_hwr) begin
      r_hmem[r_hwp[HAW-1:0]] <= w_hdr_in;
    end
  end

  assign DOUT     = r_dout;
  assign DOUT_VLD = r_dvld;
  assign HDR_OUT  = r_hdr;
  assign HDR_VLD  = r_hvld;
  assign RDY      = r_rdy;
  assign DATA_CNT = r_dcnt;
  assign DROP_CNT = r_drop;
  assign OVF      = r_ovf;

endmodule

// File: tb/tb_evt_window_buffer.sv
// Scoreboard bench for evt_window_buffer: a behavioural model pushes expected
// sample words and headers into queues as stimulus is driven; they are popped
// and compared when the DUT presents read data.
module tb_evt_window_buffer;

  localparam int NCH    = 4;
  localparam int DW     = 8;
  localparam int DAW    = 4;
  localparam int HAW    = 4;
  localparam int WW     = NCH * DW;
  localparam int DDEPTH = 1 << DAW;
  localparam int HDEPTH = 1 << HAW;

  logic          CLK;
  logic          RST_N;
  logic          RESYNC;
  logic          L1A;
  logic          L1A_MATCH;
  logic          SMP_EN;
  logic [6:0]    SAMP_MAX;
  logic [WW-1:0] DIN;
  logic          RD_EN;
  logic [WW-1:0] DOUT;
  logic          DOUT_VLD;
  logic          HDR_RD_EN;
  logic [43:0]   HDR_OUT;
  logic          HDR_VLD;
  logic          RDY;
  logic [DAW:0]  DATA_CNT;
  logic [7:0]    DROP_CNT;
  logic          OVF;

  evt_window_buffer #(.NCH(NCH), .DW(DW), .DAW(DAW), .HAW(HAW)) dut (
    .CLK(CLK), .RST_N(RST_N), .RESYNC(RESYNC), .L1A(L1A), .L1A_MATCH(L1A_MATCH),
    .SMP_EN(SMP_EN), .SAMP_MAX(SAMP_MAX), .DIN(DIN), .RD_EN(RD_EN),
    .DOUT(DOUT), .DOUT_VLD(DOUT_VLD), .HDR_RD_EN(HDR_RD_EN), .HDR_OUT(HDR_OUT),
    .HDR_VLD(HDR_VLD), .RDY(RDY), .DATA_CNT(DATA_CNT), .DROP_CNT(DROP_CNT), .OVF(OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int            m_rem;
  int            m_clr;
  int            m_drop;
  bit            m_ovf;
  logic [23:0]   m_l1a;
  logic [11:0]   m_l1am;
  logic [WW-1:0] dq[$];
  logic [43:0]   hq[$];
  logic [WW-1:0] e_dout;
  logic [43:0]   e_hdr;
  bit            e_dvld;
  bit            e_hvld;
  logic [WW-1:0] m_last_wr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_clr = 0; m_drop = 0; m_ovf = 0;
    m_l1a = 24'd0; m_l1am = 12'd0;
    dq.delete(); hq.delete();
    e_dout = '0; e_hdr = 44'd0; e_dvld = 0; e_hvld = 0;
  endtask

  // Advance the model by the current inputs, clock once, compare all outputs.
  task automatic step();
    int n, free_sp, need;
    bit acc, rej;
    logic [6:0] sh;
    if (RESYNC || m_clr > 0) begin
      dq.delete(); hq.delete();
      m_rem = 0; m_l1a = 24'd0; m_l1am = 12'd0; m_drop = 0; m_ovf = 0;
      e_dvld = 0; e_hvld = 0;
      m_clr = RESYNC ? 3 : m_clr - 1;
    end else begin
      if (L1A) m_l1a = m_l1a + 24'd1;
      if (L1A_MATCH) m_l1am = m_l1am + 12'd1;
      n       = int'(SAMP_MAX) + 1;
      free_sp = DDEPTH - dq.size() - m_rem;
      need    = n - m_rem;
      acc     = L1A_MATCH && (free_sp >= need) && (hq.size() < HDEPTH);
      rej     = L1A_MATCH && !acc;
      e_dvld  = RD_EN && (dq.size() > 0);
      if (e_dvld) e_dout = dq.pop_front();
      e_hvld  = HDR_RD_EN && (hq.size() > 0);
      if (e_hvld) e_hdr = hq.pop_front();
      if (acc) begin
        sh = (m_rem > 127) ? 7'd127 : 7'(m_rem);
        hq.push_back({(m_rem > 0) ? 1'b1 : 1'b0, sh, m_l1am, m_l1a});
      end
      if (rej) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
      if (SMP_EN && (acc || m_rem > 0)) begin
        dq.push_back(DIN);
        m_last_wr = DIN;
      end
      if (acc) m_rem = SMP_EN ? n - 1 : n;
      else if (SMP_EN && m_rem > 0) m_rem--;
    end
    @(posedge CLK);
    #1;
    check("dout_vld", DOUT_VLD, e_dvld);
    check("dout", DOUT, e_dout);
    check("hdr_vld", HDR_VLD, e_hvld);
    check("hdr_out", HDR_OUT, e_hdr);
    check("rdy", RDY, hq.size() > 0);
    check("data_cnt", DATA_CNT, dq.size());
    check("drop_cnt", DROP_CNT, m_drop);
    check("ovf", OVF, m_ovf);
    check("data_cnt_le_depth", DATA_CNT <= DDEPTH, 1);
  endtask

  task automatic cyc(input bit smp, input bit trg, input bit rd, input bit hrd);
    SMP_EN = smp; L1A = trg; L1A_MATCH = trg; RD_EN = rd; HDR_RD_EN = hrd;
    DIN = WW'($urandom);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, DOUT, 0);
    check({tag, "_dvld"}, DOUT_VLD, 0);
    check({tag, "_hdr"}, HDR_OUT, 0);
    check({tag, "_hvld"}, HDR_VLD, 0);
    check({tag, "_rdy"}, RDY, 0);
    check({tag, "_cnt"}, DATA_CNT, 0);
    check({tag, "_drop"}, DROP_CNT, 0);
    check({tag, "_ovf"}, OVF, 0);
  endtask

  initial begin
    logic [43:0] hexp;
    int vcnt;
    RST_N = 1'b0; RESYNC = 1'b0; L1A = 1'b0; L1A_MATCH = 1'b0; SMP_EN = 1'b0;
    SAMP_MAX = 7'd7; DIN = '0; RD_EN = 1'b0; HDR_RD_EN = 1'b0;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // first event: SMP_EN every second cycle, one trigger
    for (int i = 0; i < 20; i++) begin
      cyc(i % 2 == 0, i == 2, 1'b0, 1'b0);
      if (i == 2) check("t1_rdy_after_trigger", RDY, 1);
    end
    check("t1_data_cnt", DATA_CNT, 8);
    cyc(0, 0, 0, 1);
    hexp = {1'b0, 7'd0, 12'd1, 24'd1};
    check("t1_header", HDR_OUT, hexp);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);

    // overlapping trigger at REM=3
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0);
    check("t2_data_cnt", DATA_CNT, 13);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("t2_ovlp", HDR_OUT[43], 1);
    check("t2_shared", HDR_OUT[42:36], 3);
    for (int i = 0; i < 13; i++) cyc(0, 0, 1, 0);

    // fill: third trigger rejected
    for (int t = 0; t < 3; t++) begin
      cyc(1, 1, 0, 0);
      for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
    check("fill_drop", DROP_CNT, 1);
    check("fill_ovf", OVF, 1);
    check("fill_cnt", DATA_CNT, 16);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("fill_third_hdr_vld", HDR_VLD, 0);

    // drain back-to-back plus one read on empty
    vcnt = 0;
    for (int i = 0; i < 17; i++) begin
      cyc(0, 0, 1, 0);
      if (DOUT_VLD) vcnt++;
    end
    check("drain_vld_count", vcnt, 16);
    check("drain_17th_vld", DOUT_VLD, 0);
    check("drain_hold", DOUT, m_last_wr);

    // N = 17 exceeds depth: always rejected; N = 16 fits an empty FIFO
    SAMP_MAX = 7'd16;
    cyc(1, 1, 0, 0);
    check("n17_reject_drop", DROP_CNT, 2);
    check("n17_reject_cnt", DATA_CNT, 0);
    SAMP_MAX = 7'd15;
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0);
    check("n16_full_cnt", DATA_CNT, 16);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
    SAMP_MAX = 7'd0;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("n1_cnt", DATA_CNT, 1);
    cyc(0, 0, 1, 1);

    // resync mid-window; inputs during clear are ignored
    SAMP_MAX = 7'd7;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    RESYNC = 1'b1;
    cyc(1, 1, 0, 0);
    RESYNC = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    check("rs_cnt", DATA_CNT, 0);
    check("rs_rdy", RDY, 0);
    check("rs_drop", DROP_CNT, 0);
    check("rs_ovf", OVF, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 1);
    check("rs_l1amcnt", HDR_OUT[35:24], 1);
    check("rs_l1acnt", HDR_OUT[23:0], 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);

    // pointer wrap over three full fills
    SAMP_MAX = 7'd15;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0, 0);
      for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0);
      check("wrap_full_cnt", DATA_CNT, 16);
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 16; i++) cyc(0, 0, 1, 0);
    end

    // random traffic with concurrent reads/writes and one resync
    for (int i = 0; i < 400; i++) begin
      if (m_rem == 0 && hq.size() == 0) SAMP_MAX = 7'($urandom_range(0, 9));
      SMP_EN = 1'($urandom_range(0, 1));
      L1A = ($urandom_range(0, 3) == 0);
      L1A_MATCH = ($urandom_range(0, 11) == 0);
      RD_EN = ($urandom_range(0, 2) == 0);
      HDR_RD_EN = ($urandom_range(0, 3) == 0);
      RESYNC = (i == 200);
      DIN = WW'($urandom);
      step();
    end
    RESYNC = 1'b0;

    // asynchronous reset between edges
    SAMP_MAX = 7'd7;
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    SMP_EN = 1'b0; L1A = 1'b0; L1A_MATCH = 1'b0; RD_EN = 1'b0; HDR_RD_EN = 1'b0;
    #3;
    RST_N = 1'b0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #10;
    RST_N = 1'b1;
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 1);
    check("post_rst_l1amcnt", HDR_OUT[35:24], 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
